// File: rtl/his_acq_scheduler.sv
// his_acq_scheduler: per-pixel histogram acquisition sequencer for one dToF frame.
// Each pixel: clear -> coarse pass -> CH readout -> peak -> clear -> fine pass -> FH readout.
// Optional feature macro: HIS_TIMEOUT_EN (readout/peak wait timeout with sticky err_o).
module his_acq_scheduler #(
   parameter int NB      = 8,
   parameter int N_BINS  = 64,
   parameter int CSHIFT  = 2,
   parameter int N_LASER = 1024,
   parameter int N_PIX   = 16,
   parameter int TO_CYC  = 4096,
   localparam int AW     = (N_BINS > 1) ? $clog2(N_BINS) : 1,
   localparam int PW     = (N_PIX > 1) ? $clog2(N_PIX) : 1
) (
   input  logic          clk_i,
   input  logic          res_i,
   input  logic          start_i,
   input  logic          laser_sync_i,
   input  logic          tdc_vld_i,
   input  logic [NB-1:0] tdc_addr_i,
   input  logic          peak_vld_i,
   input  logic [NB-1:0] peak_bin_i,
   input  logic          rd_done_i,
   output logic [1:0]    hb_wrEn_o,
   output logic [AW-1:0] hb_addr_o,
   output logic          hb_clr_o,
   output logic          rd_req_o,
   output logic          hisNum_o,
   output logic [PW-1:0] pix_idx_o,
   output logic          busy_o,
   output logic          frame_done_o,
   output logic          err_o
);

   localparam int LW = $clog2(N_LASER + 1);
   localparam logic [AW-1:0] CLR_LAST   = AW'(N_BINS - 1);
   localparam logic [LW-1:0] LASER_LAST = LW'(N_LASER - 1);
   localparam logic [PW-1:0] PIX_LAST   = PW'(N_PIX - 1);
   localparam logic [NB:0]   NBINS_X    = (NB + 1)'(N_BINS);
   localparam logic [NB:0]   HALF_X     = (NB + 1)'(N_BINS / 2);
   localparam logic [NB:0]   TOP_X      = (NB + 1)'((1 << NB) - N_BINS);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_COARSE, S_CRD, S_PEAK, S_FINE, S_FRD, S_NEXT
   } state_t;

   state_t        state_q;
   logic [AW-1:0] clr_cnt_q;
   logic [LW-1:0] laser_q;
   logic [PW-1:0] pix_q;
   logic [NB-1:0] win_base_q;
   logic          after_peak_q;
   logic [1:0]    hb_wrEn_q;
   logic [AW-1:0] hb_addr_q;
   logic          hb_clr_q;
   logic          rd_req_q;
   logic          hisNum_q;
   logic          busy_q;
   logic          frame_done_q;

   logic [NB-1:0] cbin;
   logic          cbin_ok;
   logic [NB:0]   win_hi;
   logic          fine_ok;
   logic [NB:0]   peak_x;
   logic [NB-1:0] win_base_d;
   logic          timeout;

   // Event classification and window placement from the peak
   always_comb begin
      cbin       = tdc_addr_i >> CSHIFT;
      cbin_ok    = ({1'b0, cbin} < NBINS_X);
      win_hi     = {1'b0, win_base_q} + NBINS_X;
      fine_ok    = (tdc_addr_i >= win_base_q) && ({1'b0, tdc_addr_i} < win_hi);
      peak_x     = {1'b0, peak_bin_i};
      win_base_d = '0;
      if (peak_x < HALF_X)
         win_base_d = '0;
      else if ((peak_x - HALF_X) > TOP_X)
         win_base_d = TOP_X[NB-1:0];
      else
         win_base_d = NB'(peak_x - HALF_X);
   end

`ifdef HIS_TIMEOUT_EN
   localparam int TW = $clog2(TO_CYC + 1);
   logic [TW-1:0] to_cnt_q;
   logic          err_q;
   logic          waiting;
   logic          leave_wait;

   always_comb begin
      waiting    = (state_q == S_CRD) || (state_q == S_PEAK) || (state_q == S_FRD);
      timeout    = waiting && (to_cnt_q == TW'(TO_CYC - 1));
      leave_wait = timeout
                 || ((state_q == S_CRD || state_q == S_FRD) && rd_done_i)
                 || ((state_q == S_PEAK) && peak_vld_i);
   end

   // Cycle counter for each wait state; restarts whenever a wait state is entered
   always_ff @(posedge clk_i or negedge res_i) begin
      if (!res_i) begin
         to_cnt_q <= '0;
         err_q    <= 1'b0;
      end else begin
         if (!waiting || leave_wait)
            to_cnt_q <= '0;
         else
            to_cnt_q <= to_cnt_q + TW'(1);
         if (timeout)
            err_q <= 1'b1;
      end
   end

   assign err_o = err_q;
`else
   assign timeout = 1'b0;
   assign err_o   = 1'b0;
`endif

   // Main sequencer; every output is a register loaded on the transition that implies it.
   // A write is only loaded while sampling in COARSE/FINE, so at most the final event of a
   // pass appears one cycle after the pass ends and no stale write survives beyond that.
   always_ff @(posedge clk_i or negedge res_i) begin
      if (!res_i) begin
         state_q      <= S_IDLE;
         clr_cnt_q    <= '0;
         laser_q      <= '0;
         pix_q        <= '0;
         win_base_q   <= '0;
         after_peak_q <= 1'b0;
         hb_wrEn_q    <= 2'b00;
         hb_addr_q    <= '0;
         hb_clr_q     <= 1'b0;
         rd_req_q     <= 1'b0;
         hisNum_q     <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         hb_wrEn_q    <= 2'b00;
         if (timeout) begin
            state_q  <= S_IDLE;
            rd_req_q <= 1'b0;
            busy_q   <= 1'b0;
            hisNum_q <= 1'b0;
            frame_done_q <= 1'b1;
         end else begin
            case (state_q)
               S_IDLE: if (start_i) begin
                  state_q      <= S_CLEAR;
                  pix_q        <= '0;
                  busy_q       <= 1'b1;
                  hisNum_q     <= 1'b0;
                  after_peak_q <= 1'b0;
                  clr_cnt_q    <= '0;
                  hb_clr_q     <= 1'b1;
                  hb_addr_q    <= '0;
               end
               S_CLEAR: begin
                  if (clr_cnt_q == CLR_LAST) begin
                     hb_clr_q <= 1'b0;
                     laser_q  <= '0;
                     if (after_peak_q) begin
                        state_q      <= S_FINE;
                        hisNum_q     <= 1'b1;
                        after_peak_q <= 1'b0;
                     end else begin
                        state_q <= S_COARSE;
                     end
                  end else begin
                     clr_cnt_q <= clr_cnt_q + AW'(1);
                     hb_addr_q <= clr_cnt_q + AW'(1);
                  end
               end
               S_COARSE, S_FINE: begin
                  if (tdc_vld_i && state_q == S_COARSE && cbin_ok) begin
                     hb_wrEn_q <= 2'b11;
                     hb_addr_q <= cbin[AW-1:0];
                  end
                  if (tdc_vld_i && state_q == S_FINE && fine_ok) begin
                     hb_wrEn_q <= 2'b01;
                     hb_addr_q <= AW'(tdc_addr_i - win_base_q);
                  end
                  if (laser_sync_i) begin
                     if (laser_q == LASER_LAST) begin
                        state_q  <= (state_q == S_COARSE) ? S_CRD : S_FRD;
                        rd_req_q <= 1'b1;
                     end else begin
                        laser_q <= laser_q + LW'(1);
                     end
                  end
               end
               S_CRD, S_FRD: if (rd_done_i) begin
                  rd_req_q <= 1'b0;
                  state_q  <= (state_q == S_CRD) ? S_PEAK : S_NEXT;
               end
               S_PEAK: if (peak_vld_i) begin
                  win_base_q   <= win_base_d;
                  after_peak_q <= 1'b1;
                  state_q      <= S_CLEAR;
                  clr_cnt_q    <= '0;
                  hb_clr_q     <= 1'b1;
                  hb_addr_q    <= '0;
               end
               S_NEXT: begin
                  hisNum_q <= 1'b0;
                  if (pix_q == PIX_LAST) begin
                     state_q      <= S_IDLE;
                     busy_q       <= 1'b0;
                     frame_done_q <= 1'b1;
                  end else begin
                     pix_q     <= pix_q + PW'(1);
                     state_q   <= S_CLEAR;
                     clr_cnt_q <= '0;
                     hb_clr_q  <= 1'b1;
                     hb_addr_q <= '0;
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign hb_wrEn_o    = hb_wrEn_q;
   assign hb_addr_o    = hb_addr_q;
   assign hb_clr_o     = hb_clr_q;
   assign rd_req_o     = rd_req_q;
   assign hisNum_o     = hisNum_q;
   assign pix_idx_o    = pix_q;
   assign busy_o       = busy_q;
   assign frame_done_o = frame_done_q;

endmodule
